// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit in the MEM stage.
// Holds the RV32I access-size encodings, the access FSM state type, and helpers that
// turn an address/size pair into byte enables, store lane data, and an extended load value.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } lsu_state_e;

  // Byte enables for a store of the given size at byte offset addr.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b00:   store_be = 4'b0001 << addr;
      2'b01:   store_be = 4'b0011 << addr;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store datum across all lanes so the byte enables pick the right one.
  function automatic logic [31:0] store_align(input logic [2:0] funct3, input logic [31:0] wd);
    case (funct3[1:0])
      2'b00:   store_align = {4{wd[7:0]}};
      2'b01:   store_align = {2{wd[15:0]}};
      default: store_align = wd;
    endcase
  endfunction

  // Pick the addressed lane out of the memory word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [31:0] word,
                                              input logic [1:0]  addr);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_BU:   load_extend = {24'd0, b};
      F3_HU:   load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_be.sv
// Word-organised data memory with per-byte write enables.
// Ports: clk; WE write strobe; BE[3:0] byte enables; A word index; WD write data;
// RD combinational read data. The array has no reset.
module data_memory_be #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          WE,
  input  logic [3:0]    BE,
  input  logic [AW-1:0] A,
  input  logic [31:0]   WD,
  output logic [31:0]   RD
);

  logic [31:0] mem_q [DEPTH_WORDS];

  assign RD = mem_q[A];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (WE && BE[i]) begin
        mem_q[A][8*i +: 8] <= WD[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage_lsu.sv
// MEM stage with byte-enabled data memory, configurable wait states and MEM/WB register.
// Inputs: EX/MEM controls (RegWriteM, MemReadM, MemWriteM, ResultSrcM, Funct3M, FlushM),
// RD_M, PCPlus4M, WriteDataM, ALU_ResultM (address). Outputs: StallM (combinational pipeline
// hold) and the registered WB bundle including the extended load data and an access-fault flag.
module memory_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic        FlushM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        AccessFaultW
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // The IDLE cycle is the first stall cycle, so WAIT covers the remaining WAIT_STATES-1.
  localparam logic [2:0] CntLoad = (WAIT_STATES >= 2) ? 3'(WAIT_STATES - 2) : 3'd0;

  logic       is_mem, illegal_f3, misaligned, fault, access;
  logic       stall, complete, mem_we;
  logic [2:0] cnt_q, cnt_d;
  lsu_state_e state_q, state_d;

  logic [AW-1:0] mem_idx;
  logic [31:0]   rd_word;
  logic          unused_addr_hi;

  assign is_mem = (MemReadM | MemWriteM) & ~FlushM;

  // A simultaneous read+write is a store, so store-only legality applies.
  always_comb begin
    illegal_f3 = 1'b0;
    misaligned = 1'b0;
    case (Funct3M)
      F3_B:    misaligned = 1'b0;
      F3_H:    misaligned = ALU_ResultM[0];
      F3_W:    misaligned = |ALU_ResultM[1:0];
      F3_BU:   illegal_f3 = MemWriteM;
      F3_HU: begin
        illegal_f3 = MemWriteM;
        misaligned = ALU_ResultM[0];
      end
      default: illegal_f3 = 1'b1;
    endcase
  end

  assign fault  = is_mem & (illegal_f3 | misaligned);
  assign access = is_mem & ~fault;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && WAIT_STATES > 0) begin
          stall   = 1'b1;
          cnt_d   = CntLoad;
          state_d = (WAIT_STATES == 1) ? StDone : StWait;
        end else begin
          complete = access;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (FlushM) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        complete = access;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallM = stall;
  // Writes happen only on the completing edge, never while waiting.
  assign mem_we = complete & MemWriteM;

  // Upper address bits are ignored: out-of-range addresses wrap.
  assign mem_idx        = ALU_ResultM[AW+1:2];
  assign unused_addr_hi = ^ALU_ResultM[31:AW+2];

  data_memory_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem (
    .clk(clk),
    .WE (mem_we),
    .BE (store_be(Funct3M, ALU_ResultM[1:0])),
    .A  (mem_idx),
    .WD (store_align(Funct3M, WriteDataM)),
    .RD (rd_word)
  );

  // rd_word is the pre-write value on the completing edge, which is what a load returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 1'b0;
      RD_W         <= 5'd0;
      PCPlus4W     <= 32'd0;
      ALU_ResultW  <= 32'd0;
      ReadDataW    <= 32'd0;
      AccessFaultW <= 1'b0;
    end else if (stall) begin
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 1'b0;
      RD_W         <= 5'd0;
      PCPlus4W     <= 32'd0;
      ALU_ResultW  <= 32'd0;
      ReadDataW    <= 32'd0;
      AccessFaultW <= 1'b0;
    end else begin
      RegWriteW    <= RegWriteM & ~FlushM & ~fault;
      ResultSrcW   <= ResultSrcM;
      RD_W         <= RD_M;
      PCPlus4W     <= PCPlus4M;
      ALU_ResultW  <= ALU_ResultM;
      ReadDataW    <= load_extend(Funct3M, rd_word, ALU_ResultM[1:0]);
      AccessFaultW <= fault;
    end
  end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Bench for memory_stage_lsu: one instance with no wait states and one with three.
// Expected WB entries come from a byte-level memory model and are queued per issued
// instruction; a monitor pops and compares one entry per clock.
module tb_memory_stage_lsu;

  localparam int unsigned Depth = 64;

  typedef struct packed {
    logic        rw, rd_en, wr_en, rs;
    logic [2:0]  f3;
    logic        flush;
    logic [4:0]  rd;
    logic [31:0] pc4, wd, alu;
  } m_t;

  typedef struct packed {
    logic        rw, rs;
    logic [4:0]  rd;
    logic [31:0] pc4, alu, rdata;
    logic        fault;
  } w_t;

  typedef struct packed {
    w_t   w;
    logic chk_rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  m_t   min   [2];
  w_t   wout  [2];
  logic stall [2];

  int   ws_of  [2] = '{0, 3};
  int   wr_cnt [2] = '{0, 0};
  int   exp_wr [2] = '{0, 0};
  logic [31:0] ref_mem [2][Depth];

  exp_t sb [$];
  int   cur;
  bit   mon_on;
  int   n_chk, n_fail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    memory_stage_lsu #(
      .DEPTH_WORDS(Depth),
      .WAIT_STATES(g == 0 ? 0 : 3)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteM   (min[g].rw),
      .MemReadM    (min[g].rd_en),
      .MemWriteM   (min[g].wr_en),
      .ResultSrcM  (min[g].rs),
      .Funct3M     (min[g].f3),
      .FlushM      (min[g].flush),
      .RD_M        (min[g].rd),
      .PCPlus4M    (min[g].pc4),
      .WriteDataM  (min[g].wd),
      .ALU_ResultM (min[g].alu),
      .StallM      (stall[g]),
      .RegWriteW   (wout[g].rw),
      .ResultSrcW  (wout[g].rs),
      .RD_W        (wout[g].rd),
      .PCPlus4W    (wout[g].pc4),
      .ALU_ResultW (wout[g].alu),
      .ReadDataW   (wout[g].rdata),
      .AccessFaultW(wout[g].fault)
    );
  end

  // Write monitor: counts memory write strobes seen at each clock edge.
  always @(posedge clk) begin
    if (gen_dut[0].u_dut.mem_we) wr_cnt[0]++;
    if (gen_dut[1].u_dut.mem_we) wr_cnt[1]++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    if (wr && f3 >= 3'd4) return 1'b1;
    return (int'(a[1:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input int u, input logic [2:0] f3, input logic [31:0] a);
    int lane, sz, widx;
    logic [31:0] v;
    lane = int'(a[1:0]);
    widx = int'(a[7:2]);
    sz   = acc_size(f3);
    v    = '0;
    for (int k = 0; k < sz; k++) v |= 32'(ref_mem[u][widx][8*(lane+k) +: 8]) << (8*k);
    if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8*sz);
    return v;
  endfunction

  task automatic m_store(input int u, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    int lane, widx;
    lane = int'(a[1:0]);
    widx = int'(a[7:2]);
    for (int k = 0; k < acc_size(f3); k++) ref_mem[u][widx][8*(lane+k) +: 8] = wd[8*k +: 8];
  endtask

  function automatic m_t mk(input logic rw, input logic rd_en, input logic wr_en,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    m_t m;
    m.rw    = rw;
    m.rd_en = rd_en;
    m.wr_en = wr_en;
    m.rs    = rd_en;
    m.f3    = f3;
    m.flush = 1'b0;
    m.rd    = 5'($urandom_range(1, 31));
    m.pc4   = $urandom();
    m.wd    = wd;
    m.alu   = a;
    return m;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    e.chk_rdata = 1'b1;
    return e;
  endfunction

  // Drive one instruction into unit u, queue its expected WB entries, hold while stalled.
  task automatic issue(input int u, input logic rw, input logic rd_en, input logic wr_en,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    m_t   m;
    exp_t e;
    logic flt, acc, s;
    int   nst, n;
    m = mk(rw, rd_en, wr_en, f3, a, wd);
    @(negedge clk);
    min[u]   = m;
    min[1-u] = '0;
    cur      = u;
    mon_on   = 1'b1;
    flt = m_fault(rd_en, wr_en, f3, a);
    acc = (rd_en | wr_en) & ~flt;
    nst = acc ? ws_of[u] : 0;
    for (int i = 0; i < nst; i++) sb.push_back(bubble());
    e.w.rw      = rw & ~flt;
    e.w.rs      = m.rs;
    e.w.rd      = m.rd;
    e.w.pc4     = m.pc4;
    e.w.alu     = a;
    e.w.fault   = flt;
    e.chk_rdata = acc & rd_en;
    e.w.rdata   = (acc & rd_en) ? m_load(u, f3, a) : 32'd0;
    if (acc & wr_en) begin
      m_store(u, f3, a, wd);
      exp_wr[u]++;
    end
    sb.push_back(e);
    n = 0;
    forever begin
      #1;
      s = stall[u];
      @(posedge clk);
      if (!s) break;
      n++;
      if (n > 20) break;
      @(negedge clk);
    end
    check("stall_cycles", n, nst);
    #1;
    check("write_count", wr_cnt[u], exp_wr[u]);
  endtask

  // ---------------- monitor ----------------
  always begin
    exp_t e;
    w_t   a;
    @(posedge clk);
    #1;
    if (mon_on) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_underflow: unit %0d WB entry %0h, none expected", cur, wout[cur]);
      end else begin
        e = sb.pop_front();
        a = wout[cur];
        if (!e.chk_rdata) a.rdata = e.w.rdata;
        check("wb_entry", a, e.w);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    int          kind;
    n_chk  = 0;
    n_fail = 0;
    mon_on = 1'b0;
    cur    = 0;
    min[0] = '0;
    min[1] = '0;
    rst    = 1'b0;
    #12;
    for (int u = 0; u < 2; u++) begin
      check("reset_wb", wout[u], '0);
      check("reset_stall", stall[u], 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Give both memories known contents in words 0..15.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) issue(u, 1'b0, 1'b0, 1'b1, 3'd2, 32'(4 * i), $urandom());

    // ---- unit 0: no wait states ----
    issue(0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_deadbeef", wout[0].rdata, 32'hDEAD_BEEF);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h110, 32'h0);
    check("lw_wrap", wout[0].rdata, 32'hDEAD_BEEF);
    issue(0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h0);
    issue(0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h13, 32'h80);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h13, 32'h0);
    check("lb_sext", wout[0].rdata, 32'hFFFF_FF80);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd4, 32'h13, 32'h0);
    check("lbu_zext", wout[0].rdata, 32'h0000_0080);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_after_sb", wout[0].rdata, 32'h8000_0000);
    issue(0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h22, 32'h1234);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h22, 32'h0);
    check("lh_pos", wout[0].rdata, 32'h0000_1234);
    issue(0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h22, 32'hF00D);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd5, 32'h22, 32'h0);
    check("lhu_zext", wout[0].rdata, 32'h0000_F00D);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h22, 32'h0);
    check("lh_neg", wout[0].rdata, 32'hFFFF_F00D);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h01, 32'h0);
    check("lh_misaligned_fault", wout[0].fault, 1'b1);
    issue(0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h02, 32'h1111_1111);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd3, 32'h00, 32'h0);
    check("f3_011_fault", wout[0].fault, 1'b1);
    issue(0, 1'b0, 1'b0, 1'b1, 3'd4, 32'h04, 32'h22);
    issue(0, 1'b1, 1'b1, 1'b1, 3'd2, 32'h30, 32'h1111_2222);
    issue(0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
    check("lw_after_rw", wout[0].rdata, 32'h1111_2222);
    issue(0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h44, 32'h0);
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom() & 32'hFFFF_FF3F;
      issue(0, 1'($urandom_range(0, 1)), kind == 1 || kind == 3, kind >= 2, f3, a, $urandom());
    end

    // ---- unit 1: three wait states ----
    issue(1, 1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hCAFE_F00D);
    issue(1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    check("ws3_lw", wout[1].rdata, 32'hCAFE_F00D);
    issue(1, 1'b1, 1'b1, 1'b0, 3'd1, 32'h01, 32'h0);
    check("ws3_fault_wb", {wout[1].fault, wout[1].rw}, 2'b10);

    // Flush on the second stall cycle of a store.
    @(negedge clk);
    min[1] = mk(1'b0, 1'b0, 1'b1, 3'd2, 32'h14, 32'h5555_5555);
    min[0] = '0;
    cur    = 1;
    mon_on = 1'b1;
    sb.push_back(bubble());
    #1 check("flush_stall_1", stall[1], 1'b1);
    @(negedge clk);
    min[1].flush = 1'b1;
    sb.push_back(bubble());
    #1 check("flush_stall_2", stall[1], 1'b1);
    @(posedge clk);
    #2 check("flush_no_write", wr_cnt[1], exp_wr[1]);
    issue(1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    issue(1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h14, 32'h0);

    // Reset pulse while a store is waiting.
    @(negedge clk);
    min[1] = mk(1'b0, 1'b0, 1'b1, 3'd2, 32'h18, 32'h6666_6666);
    cur    = 1;
    mon_on = 1'b1;
    sb.push_back(bubble());
    @(posedge clk);
    #2 mon_on = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    min[1] = '0;
    #1;
    check("rst_mid_wait_wb", wout[1], '0);
    check("rst_mid_wait_stall", stall[1], 1'b0);
    #2 rst = 1'b1;
    check("rst_no_write", wr_cnt[1], exp_wr[1]);
    issue(1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h18, 32'h0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom() & 32'hFFFF_FF3F;
      issue(1, 1'($urandom_range(0, 1)), kind == 1 || kind == 3, kind >= 2, f3, a, $urandom());
    end

    #2 mon_on = 1'b0;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
